// File: rtl/pic8_pkg.sv
// -----------------------------------------------------------------------------
// pic8_pkg
// Shared types and constants for the eight-line interrupt controller.
//   state_t      : arbitration FSM state (IDLE, POST)
//   EOI_*        : command-port codes for end-of-interrupt
//   *_PORT_OFS   : register offsets from the controller's base I/O port
//   pic8_dbg_t   : observation bundle (FSM state, in-service bits, posted line)
// -----------------------------------------------------------------------------
package pic8_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      POST = 1'b1
   } state_t;

   localparam logic [7:0]  EOI_NONSPEC   = 8'h20;
   localparam logic [4:0]  EOI_SPEC_PFX  = 5'b01100;
   localparam logic [15:0] CMD_PORT_OFS  = 16'd0;
   localparam logic [15:0] MASK_PORT_OFS = 16'd1;

   typedef struct packed {
      state_t     state;
      logic [7:0] isr;
      logic [2:0] line;
   } pic8_dbg_t;

endpackage

// File: rtl/pic8_ctrl_if.sv
// -----------------------------------------------------------------------------
// pic8_ctrl_if
// Core-side bus of the interrupt controller: I/O port access plus the
// interrupt toggle handshake.
//   port/port_clk/port_w/port_o : I/O address, strobe, write flag, write data
//   dout/dout_sel               : read data and "this port is ours" flag
//   irq/intr/intl               : posted vector, request toggle, ack toggle
// Handshake: a request is outstanding while intr != intl; the controller
// flips intr to post irq and keeps irq/intr stable until the core copies
// intr into intl, which is the acknowledge.
//   master : core side      slave : controller side
// -----------------------------------------------------------------------------
interface pic8_ctrl_if;
   logic [15:0] port;
   logic        port_clk;
   logic        port_w;
   logic [7:0]  port_o;
   logic [7:0]  dout;
   logic        dout_sel;
   logic [7:0]  irq;
   logic        intr;
   logic        intl;

   modport master (
      output port, port_clk, port_w, port_o, intl,
      input  dout, dout_sel, irq, intr
   );

   modport slave (
      input  port, port_clk, port_w, port_o, intl,
      output dout, dout_sel, irq, intr
   );
endinterface

// File: rtl/pic8_prio_enc.sv
// -----------------------------------------------------------------------------
// pic8_prio_enc
// 8-bit lowest-index-wins priority encoder.
//   req   in  8 : request vector
//   valid out 1 : any request bit set
//   idx   out 3 : index of the lowest set bit (0 when none)
// -----------------------------------------------------------------------------
module pic8_prio_enc (
   input  logic [7:0] req,
   output logic       valid,
   output logic [2:0] idx
);

   always_comb begin
      valid = |req;
      idx   = 3'd0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) idx = 3'(i);
      end
   end

endmodule

// File: rtl/pic8_ctrl.sv
// -----------------------------------------------------------------------------
// pic8_ctrl
// Eight-line edge-triggered interrupt controller with fixed priority
// (line 0 highest), mask register, in-service tracking and EOI commands.
//   clock    in  1 : system clock, rising edge
//   reset_n  in  1 : synchronous active-low reset (only while locked)
//   locked   in  1 : PLL lock; all state holds while low
//   irq_in   in  8 : asynchronous peripheral request lines (rising edge)
//   bus      slave : core port bus and intr/intl toggle handshake
//   dbg      out   : FSM state, in-service bits, latched line
// Registers: BASE_PORT reads IRR / takes EOI commands,
//            BASE_PORT+1 reads and writes IMR.
// -----------------------------------------------------------------------------
module pic8_ctrl
   import pic8_pkg::*;
#(
   parameter logic [15:0] BASE_PORT   = 16'h0020,
   parameter logic [7:0]  VECTOR_BASE = 8'h08
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        locked,
   input  logic [7:0]  irq_in,
   pic8_ctrl_if.slave  bus,
   output pic8_dbg_t   dbg
);

   logic [7:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic       pclk_q, pclk_d;
   logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
   logic [7:0] irq_q, irq_d;
   logic       intr_q, intr_d;
   logic [2:0] line_q, line_d;
   state_t     state_q, state_d;

   logic [7:0] rise;
   logic       wr_stb, cmd_hit, mask_hit, ack;
   logic       cand_valid, isr_valid, eligible;
   logic [2:0] cand_idx, isr_idx;

   assign rise     = sync2_q & ~prev_q;
   assign wr_stb   = bus.port_clk & ~pclk_q & bus.port_w;
   assign cmd_hit  = (bus.port == 16'(BASE_PORT + CMD_PORT_OFS));
   assign mask_hit = (bus.port == 16'(BASE_PORT + MASK_PORT_OFS));

   pic8_prio_enc u_cand (.req(irr_q & ~imr_q), .valid(cand_valid), .idx(cand_idx));
   pic8_prio_enc u_isr  (.req(isr_q),          .valid(isr_valid),  .idx(isr_idx));

   // A candidate may only pre-empt strictly lower-priority in-service lines.
   assign eligible = cand_valid && (!isr_valid || (cand_idx < isr_idx));

   always_comb begin
      sync1_d = irq_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      pclk_d  = bus.port_clk;
      state_d = state_q;
      irq_d   = irq_q;
      intr_d  = intr_q;
      line_d  = line_q;
      irr_d   = irr_q;
      isr_d   = isr_q;
      imr_d   = imr_q;
      ack     = 1'b0;

      case (state_q)
         IDLE: begin
            if ((intr_q == bus.intl) && eligible) begin
               irq_d   = VECTOR_BASE + {5'b00000, cand_idx};
               line_d  = cand_idx;
               intr_d  = ~intr_q;
               state_d = POST;
            end
         end
         POST: begin
            if (bus.intl == intr_q) begin
               ack     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // EOI acts on the ISR as it was at the start of the cycle.
      if (wr_stb && cmd_hit) begin
         if (bus.port_o == EOI_NONSPEC) begin
            if (isr_valid) isr_d[isr_idx] = 1'b0;
         end else if (bus.port_o[7:3] == EOI_SPEC_PFX) begin
            isr_d[bus.port_o[2:0]] = 1'b0;
         end
      end
      if (wr_stb && mask_hit) imr_d = bus.port_o;

      // Ack bookkeeping is applied last so its sets win over clears.
      if (ack) begin
         irr_d[line_q] = 1'b0;
         isr_d[line_q] = 1'b1;
      end
      irr_d = irr_d | rise;
   end

   always_ff @(posedge clock) begin
      if (locked) begin
         if (!reset_n) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            prev_q  <= 8'h00;
            pclk_q  <= 1'b0;
            irr_q   <= 8'h00;
            isr_q   <= 8'h00;
            imr_q   <= 8'hFF;
            irq_q   <= 8'h00;
            intr_q  <= bus.intl;
            line_q  <= 3'd0;
            state_q <= IDLE;
         end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pclk_q  <= pclk_d;
            irr_q   <= irr_d;
            isr_q   <= isr_d;
            imr_q   <= imr_d;
            irq_q   <= irq_d;
            intr_q  <= intr_d;
            line_q  <= line_d;
            state_q <= state_d;
         end
      end
   end

   always_comb begin
      bus.dout = 8'h00;
      if (cmd_hit)       bus.dout = irr_q;
      else if (mask_hit) bus.dout = imr_q;
   end

   assign bus.dout_sel = cmd_hit | mask_hit;
   assign bus.irq      = irq_q;
   assign bus.intr     = intr_q;

   assign dbg.state = state_q;
   assign dbg.isr   = isr_q;
   assign dbg.line  = line_q;

endmodule
